// File: rtl/mem_access_sequencer_if.sv
// Byte-wide data-memory port between the load/store sequencer and memory.
interface mem_access_sequencer_if #(
    parameter int unsigned NB_ADDR = 32
);
    logic [NB_ADDR-1:0] mem_addr;
    logic [7:0]         mem_wdata;
    logic               mem_re;
    logic               mem_we;
    logic [7:0]         mem_rdata;
    logic               mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_re,
        output mem_we,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_re,
        input  mem_we,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Sequences RV32I loads/stores onto a byte-wide memory port, one byte per
// handshake, with sign/zero extension of load data and illegal-access flagging.
module mem_access_sequencer #(
    parameter int unsigned NB_ADDR = 32,
    parameter int unsigned NB_DATA = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic [1:0]         i_dataSize,
    input  logic               i_unsigned,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_wdata,
    output logic               o_stall,
    output logic               o_done,
    output logic               o_err,
    output logic [NB_DATA-1:0] o_rdata,
    mem_access_sequencer_if.master mem
);

    localparam int unsigned NB_BYTE = 8;
    localparam int unsigned NB_IDX  = 2;

    typedef enum logic [1:0] {IDLE, XFER, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic [NB_ADDR-1:0]  addr_q, addr_d;
    logic [NB_DATA-1:0]  wdata_q, wdata_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                rd_q, rd_d;
    logic [NB_IDX-1:0]   k_q, k_d;
    logic [NB_IDX-1:0]   last_q, last_d;
    logic [NB_DATA-1:0]  asm_q, asm_d;
    logic [NB_DATA-1:0]  rdata_q, rdata_d;
    logic [NB_ADDR-1:0]  mem_addr_q, mem_addr_d;
    logic [NB_BYTE-1:0]  mem_wdata_q, mem_wdata_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                aligned;
    logic                req_any;
    logic                req_legal;
    logic [NB_DATA-1:0]  asm_mrg;
    logic [NB_DATA-1:0]  ext;

    // Request classification: size 00 is never aligned, so it lands in ERR.
    always_comb begin
        aligned = 1'b0;
        case (i_dataSize)
            2'b01:   aligned = 1'b1;
            2'b10:   aligned = ~i_addr[0];
            2'b11:   aligned = (i_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign req_any   = i_start & (i_memRead | i_memWrite);
    assign req_legal = req_any & (i_memRead ^ i_memWrite) & aligned;

    // Stall freezes the pipeline in the request cycle itself, so it is combinational.
    assign o_stall = ~i_rst & (((state_q == IDLE) & req_legal) | (state_q == XFER));

    // Merge the incoming byte into the assembly register and extend by size.
    always_comb begin
        asm_mrg = asm_q;
        asm_mrg[{k_q, 3'b000} +: NB_BYTE] = mem.mem_rdata;
        ext = asm_mrg;
        case (size_q)
            2'b01:   ext = {{(NB_DATA - 8){~uns_q & asm_mrg[7]}}, asm_mrg[7:0]};
            2'b10:   ext = {{(NB_DATA - 16){~uns_q & asm_mrg[15]}}, asm_mrg[15:0]};
            default: ext = asm_mrg;
        endcase
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        k_d     = k_q;
        last_d  = last_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (req_legal) begin
                        addr_d  = i_addr;
                        wdata_d = i_wdata;
                        size_d  = i_dataSize;
                        uns_d   = i_unsigned;
                        rd_d    = i_memRead;
                        k_d     = '0;
                        asm_d   = '0;
                        case (i_dataSize)
                            2'b01:   last_d = NB_IDX'(0);
                            2'b10:   last_d = NB_IDX'(1);
                            default: last_d = NB_IDX'(3);
                        endcase
                        state_d = XFER;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            XFER: begin
                if (mem.mem_ready) begin
                    if (rd_q) begin
                        asm_d = asm_mrg;
                    end
                    if (k_q == last_q) begin
                        state_d = DONE;
                        if (rd_q) begin
                            rdata_d = ext;
                        end
                    end else begin
                        k_d = k_q + NB_IDX'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mem_re_d    = (state_d == XFER) & rd_d;
        mem_we_d    = (state_d == XFER) & ~rd_d;
        mem_addr_d  = (state_d == XFER) ? (addr_d + NB_ADDR'(k_d)) : '0;
        mem_wdata_d = (state_d == XFER) ? wdata_d[{k_d, 3'b000} +: NB_BYTE] : '0;
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERR);
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            rd_q        <= 1'b0;
            k_q         <= '0;
            last_q      <= '0;
            asm_q       <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            rd_q        <= rd_d;
            k_q         <= k_d;
            last_q      <= last_d;
            asm_q       <= asm_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign o_done        = done_q;
    assign o_err         = err_q;
    assign o_rdata       = rdata_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_re    = mem_re_q;
    assign mem.mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: expected byte handshakes and
// completions are queued when a request is driven, and retired as the DUT
// produces them.
module tb_mem_access_sequencer;

    typedef struct {
        logic [1:0]  kind;   // 0 read byte, 1 write byte, 2 done, 3 err
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  dsize;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        o_stall;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_rdata;

    int          n_vec;
    int          n_err;
    int          wcnt;
    int          wait_cfg;
    logic [31:0] rdata_model;
    ev_t         exp_q[$];
    logic [7:0]  mem [int unsigned];

    mem_access_sequencer_if #(.NB_ADDR(32)) bus ();

    mem_access_sequencer #(.NB_ADDR(32), .NB_DATA(32)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_memRead  (mem_read),
        .i_memWrite (mem_write),
        .i_dataSize (dsize),
        .i_unsigned (uns),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .o_stall    (o_stall),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_rdata    (o_rdata),
        .mem        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_ready = (wcnt == wait_cfg);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // Memory model: ready after wait_cfg stalled cycles per byte, writes on accept.
    always @(posedge clk) begin
        if (rst) begin
            wcnt <= 0;
        end else if (bus.mem_re || bus.mem_we) begin
            if (bus.mem_ready) begin
                wcnt <= 0;
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    // Monitor: present read data and retire expected events.
    always @(negedge clk) begin
        ev_t e;
        bus.mem_rdata = mem_byte(bus.mem_addr);
        if (!rst) begin
            if (bus.mem_re || bus.mem_we) begin
                if (exp_q.size() == 0) begin
                    check_val("unexp_strobe", 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    check_val("strobe", {30'd0, bus.mem_we, bus.mem_re},
                              (e.kind == 2'd1) ? 32'd2 : (e.kind == 2'd0) ? 32'd1 : 32'd0);
                    check_val("mem_addr", bus.mem_addr, e.addr);
                    if (e.kind == 2'd1) check_val("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, e.data[7:0]});
                    if (bus.mem_ready) void'(exp_q.pop_front());
                end
            end
            if (o_done || o_err) begin
                if (exp_q.size() == 0) begin
                    check_val("unexp_done_err", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("done_err", {30'd0, o_err, o_done},
                              (e.kind == 2'd2) ? 32'd1 : (e.kind == 2'd3) ? 32'd2 : 32'd0);
                    check_val("rdata", o_rdata, e.data);
                end
            end
        end
    end

    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd, input int w);
        int          n;
        int          lat;
        int          cyc;
        logic        legal;
        logic [31:0] asmv;
        logic [31:0] expv;
        ev_t         e;
        n     = (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : (sz == 2'b11) ? 4 : 0;
        legal = (rd ^ wr) && (sz != 2'b00) && !(sz == 2'b10 && a[0])
                && !(sz == 2'b11 && a[1:0] != 2'b00);
        lat   = 0;
        @(negedge clk);
        wait_cfg  = w;
        start     = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        dsize     = sz;
        uns       = un;
        addr      = a;
        wdata     = wd;
        if (legal) begin
            asmv = '0;
            for (int k = 0; k < n; k++) begin
                e.kind = wr ? 2'd1 : 2'd0;
                e.addr = a + 32'(k);
                e.data = {24'd0, wd[8*k +: 8]};
                if (rd) asmv[8*k +: 8] = mem_byte(a + 32'(k));
                exp_q.push_back(e);
            end
            if (rd) begin
                case (sz)
                    2'b01:   expv = un ? {24'd0, asmv[7:0]} : {{24{asmv[7]}}, asmv[7:0]};
                    2'b10:   expv = un ? {16'd0, asmv[15:0]} : {{16{asmv[15]}}, asmv[15:0]};
                    default: expv = asmv;
                endcase
                rdata_model = expv;
            end
            e.kind = 2'd2; e.addr = '0; e.data = rdata_model;
            exp_q.push_back(e);
            lat = n * (w + 1) + 1;
        end else if (rd || wr) begin
            e.kind = 2'd3; e.addr = '0; e.data = rdata_model;
            exp_q.push_back(e);
            lat = 1;
        end
        #1 check_val("stall_t0", {31'd0, o_stall}, {31'd0, legal});
        @(negedge clk);
        start     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (!(rd || wr)) begin
            for (int i = 0; i < 3; i++) begin
                check_val("ignored_idle", {29'd0, o_stall, o_done, o_err}, 32'd0);
                @(negedge clk);
            end
        end else begin
            cyc = 1;
            while (!(o_done || o_err) && cyc < 200) begin
                check_val("stall_busy", {31'd0, o_stall}, {31'd0, legal});
                @(negedge clk);
                cyc++;
            end
            check_val("latency", 32'(cyc), 32'(lat));
            check_val("stall_end", {31'd0, o_stall}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val(tag, {o_stall, o_done, o_err, bus.mem_re, bus.mem_we, 27'd0}, 32'd0);
        check_val(tag, o_rdata, 32'd0);
        check_val(tag, bus.mem_addr, 32'd0);
        check_val(tag, {24'd0, bus.mem_wdata}, 32'd0);
    endtask

    initial begin
        ev_t e;
        logic [1:0]  sz;
        logic        rd;
        logic [31:0] a;
        n_vec = 0; n_err = 0; wcnt = 0; wait_cfg = 0; rdata_model = '0;
        rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        dsize = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        mem[32'h203] = 8'h80;
        mem[32'h020] = 8'h01; mem[32'h021] = 8'h80;
        for (int i = 32'h300; i < 32'h400; i++) mem[i] = 8'($urandom);

        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;

        run_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0);          // LW
        check_val("lw_value", o_rdata, 32'h12345678);
        run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h203, 32'h0, 0);          // LB
        check_val("lb_value", o_rdata, 32'hFFFFFF80);
        run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h203, 32'h0, 0);          // LBU
        check_val("lbu_value", o_rdata, 32'h00000080);
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 0);   // SH
        check_val("sh_b0", {24'd0, mem_byte(32'h10)}, 32'hEF);
        check_val("sh_b1", {24'd0, mem_byte(32'h11)}, 32'hBE);
        check_val("sh_b2_untouched", {24'd0, mem_byte(32'h12)}, 32'h00);
        check_val("sh_rdata_kept", o_rdata, 32'h00000080);
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 2);          // LH with waits
        check_val("lh_value", o_rdata, 32'hFFFF8001);
        run_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h102, 32'h0, 0);          // misaligned LW
        run_op(1'b1, 1'b1, 2'b11, 1'b0, 32'h100, 32'h0, 0);          // both directions
        run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 0);          // size 00
        run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h021, 32'h0, 0);          // misaligned SH
        check_val("err_rdata_kept", o_rdata, 32'hFFFF8001);
        run_op(1'b0, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0);          // no direction

        // SW interrupted by reset in its second byte cycle.
        @(negedge clk);
        wait_cfg = 0; start = 1'b1; mem_write = 1'b1; dsize = 2'b11;
        addr = 32'h40; wdata = 32'hCAFEF00D;
        for (int k = 0; k < 4; k++) begin
            e.kind = 2'd1; e.addr = 32'h40 + 32'(k); e.data = {24'd0, wdata[8*k +: 8]};
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("reset_mid_xfer");
        exp_q.delete();
        rdata_model = '0;
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_b0_written", {24'd0, mem_byte(32'h40)}, 32'h0D);
        check_val("rst_b1_abandoned", {24'd0, mem_byte(32'h41)}, 32'h00);
        run_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0);
        check_val("lw_after_rst", o_rdata, 32'h12345678);

        // Random aligned loads and stores with random memory wait states.
        for (int i = 0; i < 24; i++) begin
            sz = 2'($urandom_range(1, 3));
            rd = 1'($urandom_range(0, 1));
            a  = 32'h300 | ($urandom & 32'hFC);
            if (sz == 2'b01) a = a | ($urandom & 32'h3);
            if (sz == 2'b10) a = a | ($urandom & 32'h2);
            run_op(rd, ~rd, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
